jtframe_mister_pll: RTL and testbench
=====================================

# jtframe_mister_pll

PLL lock supervisor and reset generator for the MiSTer JTFRAME wrapper. It watches the PLL `locked` flag and drives a 256-cycle `pll_rst` pulse whenever lock is lost, so the PLL re-acquires. It also produces the synchronised system reset (`rst`/`rst_n`) and the game-core reset (`game_rst`/`game_rst_n`) from the board reset, the OSD/button reset request and the ROM-download state. It sits between the PLL and the frame/game logic, clocked by the system clock (48 MHz, or 96 MHz in CLK96 builds).

## Interface
Parameters:
- `LOCKLOSS_HOLD`, default 8'hFF: value loaded into the lock-loss counter on a lock-loss edge.
- `CNT_INIT`, default 8'hD0: lock-loss counter value while RESET is asserted.
- `RST_HOLD`, default 16: cycles `rst` stays high after the reset condition clears (≥1).

Ports:
- `clk_sys`  in  1  system clock.
- `RESET`  in  1  reset RESET, asynchronous, active-high; clock clk_sys.
- `pll_locked`  in  1  PLL lock flag.
- `rst_req`  in  1  reset request (OSD status[0] | button[1]); asynchronous.
- `downloading`  in  1  ROM download in progress; clk_sys domain.
- `pll_rst`  out  1  PLL reset, active-high.
- `rst`, `rst_n`  out  1  system reset and its complement.
- `game_rst`, `game_rst_n`  out  1  game reset and its complement.

## Operation
- Reset state while RESET=1, applied asynchronously:
  - `pll_rst`=0, counter=`CNT_INIT`, `last_locked`=0.
  - Sync flops `lock_s`=0 and `req_s`=0.
  - `rst`=1, `rst_n`=0, `game_rst`=1, `game_rst_n`=0.
- Lock supervisor, every edge:
  - `last_locked <= pll_locked`, using raw `pll_locked` with no synchroniser.
  - If `last_locked && !pll_locked`: counter <= `LOCKLOSS_HOLD` and `pll_rst <= 1`.
  - Else if counter != 0: counter decrements.
  - Else: `pll_rst <= 0`.
  - The counter leaving RESET at `CNT_INIT` counts down silently and never asserts `pll_rst`.
- Reset condition:
  - `pll_locked` and `rst_req` each pass through a 2-flop synchroniser, giving `lock_s` and `req_s`.
  - `cond = !lock_s | req_s`.
- Hold counter: loaded with `RST_HOLD` on every edge that samples `cond`=1; otherwise decrements to 0.
- `rst` is registered and deasserts exactly `RST_HOLD` edges after the last edge that sampled `cond`=1.
- `rst` asserts on the first edge that samples `cond`=1, or asynchronously on RESET.
- `game_rst <= rst | downloading`, registered.
- `rst_n` = ~`rst` and `game_rst_n` = ~`game_rst`, each from the same register (always complementary).

## Timing
- `pll_rst` rises on the edge that samples `last_locked`=1 and `pll_locked`=0.
- With the default `LOCKLOSS_HOLD`, `pll_rst` stays high for exactly 256 cycles.
- A new lock-loss edge while `pll_rst` is high reloads the counter, so the 256-cycle window restarts.
- `pll_locked` toggling back to 1 does not shorten the `pll_rst` pulse.
- RESET while `pll_rst` is high drops `pll_rst` immediately.
- Lock-loss to `rst` high: 3 edges (2 sync + 1 register).
- `game_rst` lags `rst` by 1 edge at both assertion and deassertion; it stays high while `downloading`=1 regardless of `rst`.
- `rst_req` pulses shorter than one clk_sys period may be missed; the requester holds them ≥2 cycles.

## Test plan
- Power-on:
  - Stimulus: `pll_locked`=1 and `rst_req`=0 throughout; RESET released.
  - Required: `pll_rst` stays 0; `rst` falls on edge 18 after RESET release; `game_rst` falls on edge 19.
- Lock loss:
  - Stimulus: `pll_locked` 1→0 for 5 cycles, then back to 1, after `rst` has cleared.
  - Required: `pll_rst` high for exactly 256 cycles; `rst` high from edge 3 after the drop.
  - Required: `rst` falls 18 edges after `pll_locked` returns.
- Re-trigger:
  - Stimulus: second 1→0 lock transition 100 cycles into the `pll_rst` pulse.
  - Required: `pll_rst` stays high until 256 cycles after the second edge (356 total).
- Reset request:
  - Stimulus: `rst_req` high for 3 cycles with lock stable.
  - Required: `rst` rises 3 edges after `rst_req` rises; falls 16 edges after the last edge sampling `req_s`=1.
- Download:
  - Stimulus: `downloading`=1 for 1000 cycles, `rst`=0.
  - Required: `game_rst` high from the next edge until 1 edge after `downloading` falls; `rst` stays 0.
- Mid-operation reset:
  - Stimulus: RESET pulse while `pll_rst`=1.
  - Required: `pll_rst`=0 immediately; counter=8'hD0; `rst`/`game_rst`=1; no `pll_rst` after release.

Source files
------------

// File: rtl/jtframe_mister_pll.sv
// -----------------------------------------------------------------------------
// jtframe_mister_pll
//
// PLL lock supervisor and reset generator for the MiSTer JTFRAME wrapper.
//
// Lock supervisor:
//   A falling edge on pll_locked fires a pll_rst pulse of LOCKLOSS_HOLD+1 cycles,
//   so the PLL gets a clean reset and can re-acquire lock. Another lock-loss
//   edge during the pulse reloads the counter and restarts the window.
//
// Reset generator:
//   rst is held high while the synchronised lock flag is low or a reset request
//   is active. It stays high for RST_HOLD more edges after the condition
//   clears. game_rst follows rst one edge later. It is also held high during a
//   ROM download.
//
// Ports:
//   clk_sys      in   system clock (48 MHz, 96 MHz in CLK96 builds)
//   RESET        in   board reset, asynchronous, active-high
//   pll_locked   in   PLL lock flag (asynchronous to clk_sys)
//   rst_req      in   OSD / button reset request (asynchronous)
//   downloading  in   ROM download in progress (clk_sys domain)
//   pll_rst      out  PLL reset, active-high
//   rst, rst_n   out  system reset and its complement
//   game_rst,    out  game-core reset and its complement
//   game_rst_n
// -----------------------------------------------------------------------------
module jtframe_mister_pll #(
  parameter logic [7:0]  LOCKLOSS_HOLD = 8'hFF,
  parameter logic [7:0]  CNT_INIT      = 8'hD0,
  parameter int unsigned RST_HOLD      = 16
) (
  input  logic clk_sys,
  input  logic RESET,
  input  logic pll_locked,
  input  logic rst_req,
  input  logic downloading,
  output logic pll_rst,
  output logic rst,
  output logic rst_n,
  output logic game_rst,
  output logic game_rst_n
);

  localparam int unsigned           HOLD_W    = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0]     HOLD_ONE  = HOLD_W'(1);

  // ---------------------------------------------------------------------------
  // Lock supervisor
  // ---------------------------------------------------------------------------
  logic       r_last_locked;
  logic [7:0] r_cnt;
  logic       r_pll_rst;

  // The edge detector deliberately samples raw pll_locked. A metastable
  // sample can at worst add or drop a single lock-loss event. The PLL
  // reset that follows covers either outcome.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_last_locked <= 1'b0;
      r_cnt         <= CNT_INIT;
      r_pll_rst     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // so r_last_locked below is still the previous cycle's lock flag.
      r_last_locked <= pll_locked;
      if (r_last_locked && !pll_locked) begin
        r_cnt     <= LOCKLOSS_HOLD;
        r_pll_rst <= 1'b1;
      end else if (r_cnt != 8'd0) begin
        // The countdown from CNT_INIT after RESET runs with r_pll_rst low.
        // This path never sets it, so that countdown stays silent.
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_pll_rst <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the lock flag and the reset request
  // ---------------------------------------------------------------------------
  logic [1:0] r_lock_sync;
  logic [1:0] r_req_sync;
  logic       w_cond;

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_lock_sync <= 2'b00;
      r_req_sync  <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_locked};
      r_req_sync  <= {r_req_sync[0],  rst_req};
    end
  end

  assign w_cond = ~r_lock_sync[1] | r_req_sync[1];

  // ---------------------------------------------------------------------------
  // Reset hold counter and registered resets
  // ---------------------------------------------------------------------------
  logic [HOLD_W-1:0] r_hold;
  logic              r_rst;
  logic              r_game_rst;

  // r_hold is reloaded on every edge that sees w_cond. After the last such
  // edge it reads RST_HOLD, then RST_HOLD-1, and so on. rst stays high while
  // the pre-edge count is still above one, so it drops exactly RST_HOLD edges
  // after the last edge with the condition set.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      r_hold     <= HOLD_LOAD;
      r_rst      <= 1'b1;
      r_game_rst <= 1'b1;
    end else begin
      if (w_cond) begin
        r_hold <= HOLD_LOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_ONE;
      end
      r_rst      <= w_cond | (r_hold > HOLD_ONE);
      r_game_rst <= r_rst | downloading;
    end
  end

  // Both polarities come from one register each, so they never glitch apart.
  assign pll_rst    = r_pll_rst;
  assign rst        = r_rst;
  assign rst_n      = ~r_rst;
  assign game_rst   = r_game_rst;
  assign game_rst_n = ~r_game_rst;

endmodule

// File: tb/tb_jtframe_mister_pll.sv
// -----------------------------------------------------------------------------
// tb_jtframe_mister_pll
//
// Bench for jtframe_mister_pll with default parameters. It checks the DUT
// against a history-based reference model that works from sampled input
// history:
//   - pll_rst is high after edge t when a lock-loss edge k (pll_locked 1 at
//     edge k-1, 0 at edge k, k >= 2 after RESET release) has 0 <= t-k < 256.
//   - the reset condition at edge t uses the inputs from edge t-2, which is the
//     sync depth. It is forced true on edges 1 and 2, when the synchroniser
//     still holds its reset zeros.
//   - rst is high after edge t when the condition held at some edge c with
//     0 <= t-c < RST_HOLD.
//   - game_rst after edge t = rst after edge t-1 | downloading at edge t.
// Directed phases then measure the exact edges where outputs toggle.
// -----------------------------------------------------------------------------
module tb_jtframe_mister_pll;

  localparam int RST_HOLD = 16;
  localparam int PULSE    = 256;

  logic clk_sys     = 1'b0;
  logic RESET       = 1'b1;
  logic pll_locked  = 1'b1;
  logic rst_req     = 1'b0;
  logic downloading = 1'b0;
  logic pll_rst, rst, rst_n, game_rst, game_rst_n;

  int total = 0;
  int bad   = 0;

  jtframe_mister_pll dut (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .pll_locked (pll_locked),
    .rst_req    (rst_req),
    .downloading(downloading),
    .pll_rst    (pll_rst),
    .rst        (rst),
    .rst_n      (rst_n),
    .game_rst   (game_rst),
    .game_rst_n (game_rst_n)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference-model state: input history since the last RESET release.
  bit lq[$];
  bit rq[$];
  bit dq[$];
  int t;
  int last_loss;
  int last_cond;
  bit m_prev_rst;

  // Observed transition bookkeeping, indexed by edge number t.
  bit o_pll, o_rst, o_game;
  int pll_rise, pll_fall, pll_rises;
  int rst_rise, rst_fall, rst_rises;
  int game_rise, game_fall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    lq.delete(); rq.delete(); dq.delete();
    t          = 0;
    last_loss  = -100000;
    last_cond  = -100000;
    m_prev_rst = 1'b1;
    o_pll = 1'b0; o_rst = 1'b1; o_game = 1'b1;
    pll_rise = -1; pll_fall = -1; pll_rises = 0;
    rst_rise = -1; rst_fall = -1; rst_rises = 0;
    game_rise = -1; game_fall = -1;
  endtask

  // One clock edge: record sampled inputs, evaluate model, check outputs.
  task automatic step();
    bit e_pll, e_rst, e_game;
    @(posedge clk_sys);
    lq.push_back(pll_locked);
    rq.push_back(rst_req);
    dq.push_back(downloading);
    t++;
    if (t >= 2 && lq[t-2] && !lq[t-1]) last_loss = t;
    if (t <= 2 || !lq[t-3] || rq[t-3]) last_cond = t;
    e_pll      = (t - last_loss) < PULSE;
    e_rst      = (t - last_cond) < RST_HOLD;
    e_game     = m_prev_rst | dq[t-1];
    m_prev_rst = e_rst;
    #1;
    check("pll_rst",    pll_rst,    e_pll);
    check("rst",        rst,        e_rst);
    check("rst_n",      rst_n,      !e_rst);
    check("game_rst",   game_rst,   e_game);
    check("game_rst_n", game_rst_n, !e_game);
    if (!o_pll && pll_rst)   begin pll_rise = t; pll_rises++; end
    if (o_pll && !pll_rst)   pll_fall = t;
    if (!o_rst && rst)       begin rst_rise = t; rst_rises++; end
    if (o_rst && !rst)       rst_fall = t;
    if (!o_game && game_rst) game_rise = t;
    if (o_game && !game_rst) game_fall = t;
    o_pll = pll_rst; o_rst = rst; o_game = game_rst;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pll_rst"},    pll_rst,    1'b0);
    check({tag, "_cnt"},        dut.r_cnt,  8'hD0);
    check({tag, "_rst"},        rst,        1'b1);
    check({tag, "_rst_n"},      rst_n,      1'b0);
    check({tag, "_game_rst"},   game_rst,   1'b1);
    check({tag, "_game_rst_n"}, game_rst_n, 1'b0);
  endtask

  int t0, t1, tr;
  int run_len;

  initial begin
    model_reset();

    // Reset state, then power-on with stable lock.
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_state("reset");
    @(negedge clk_sys);
    RESET = 1'b0;
    model_reset();
    steps(25);
    check("poweron_rst_fall",  rst_fall,  18);
    check("poweron_game_fall", game_fall, 19);
    check("poweron_no_pll",    pll_rises, 0);

    // Lock loss for 5 cycles.
    pll_rises = 0; rst_rises = 0;
    t0 = t;
    pll_locked = 1'b0;
    steps(5);
    pll_locked = 1'b1;
    tr = t;
    steps(300);
    check("loss_pll_rise",  pll_rise, t0 + 1);
    check("loss_pll_width", pll_fall - pll_rise, PULSE);
    check("loss_rst_rise",  rst_rise, t0 + 3);
    check("loss_rst_fall",  rst_fall, tr + 18);

    // Re-trigger: second lock-loss edge 100 cycles into the pulse.
    pll_rises = 0;
    t0 = t;
    pll_locked = 1'b0;
    steps(5);
    pll_locked = 1'b1;
    steps(95);
    t1 = t;
    pll_locked = 1'b0;
    steps(5);
    pll_locked = 1'b1;
    steps(400);
    check("retrig_rises", pll_rises, 1);
    check("retrig_fall",  pll_fall, t1 + 1 + PULSE);
    check("retrig_width", pll_fall - pll_rise, 100 + PULSE);

    // Reset request held for 3 cycles.
    pll_rises = 0; rst_rises = 0;
    t0 = t;
    rst_req = 1'b1;
    steps(3);
    rst_req = 1'b0;
    steps(30);
    check("req_rst_rise", rst_rise, t0 + 3);
    check("req_rst_fall", rst_fall, t0 + 5 + RST_HOLD);
    check("req_no_pll",   pll_rises, 0);

    // Download for 1000 cycles.
    rst_rises = 0;
    t0 = t;
    downloading = 1'b1;
    steps(1000);
    downloading = 1'b0;
    t1 = t;
    steps(5);
    check("dl_game_rise", game_rise, t0 + 1);
    check("dl_game_fall", game_fall, t1 + 1);
    check("dl_no_rst",    rst_rises, 0);

    // RESET in the middle of a pll_rst pulse.
    pll_locked = 1'b0;
    steps(3);
    pll_locked = 1'b1;
    steps(20);
    check("mid_pre_pll", pll_rst, 1'b1);
    RESET = 1'b1;
    #1;
    check_reset_state("mid");
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    RESET = 1'b0;
    model_reset();
    steps(300);
    check("mid_no_pll",    pll_rises, 0);
    check("mid_rst_fall",  rst_fall, 18);

    // Randomised traffic checked edge-by-edge against the model.
    for (int n = 0; n < 3000; n += run_len) begin
      run_len     = $urandom_range(2, 40);
      pll_locked  = ($urandom_range(0, 3) != 0);
      rst_req     = ($urandom_range(0, 7) == 0);
      downloading = ($urandom_range(0, 5) == 0);
      steps(run_len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
